perf_counter_unit: RTL
======================

Name: perf_counter_unit

Overview:
- On-chip, memory-mapped performance monitor for the pipelined LEG core.
- Counts the pipeline events the simulation profiler gathers: cycles, instructions, branches, cache stalls, ldr stalls, flushes and wasted cycles.
- Exposes the counts as registers so software (e.g. Dhrystone) can read them on silicon.
- Sits beside the data memory and is selected by the top-level address decoder.

Parameters:
- W, 32, counter width in bits; also the bus data width.
- EN_RESET, 1, reset value of CTRL.EN (1 = counting starts right after reset).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- InstrE  in  32  instruction currently in Execute
- BranchE  in  1  instruction in Execute is a branch
- BranchTakenE  in  1  branch in Execute is taken
- StallE  in  1  Execute stage stalled
- IStall  in  1  instruction-cache miss stall
- DStall  in  1  data-cache miss stall
- ldrStallD  in  1  load-use stall in Decode
- FlushD  in  1  Decode flush
- FlushE  in  1  Execute flush
- PCSrcW  in  1  PC written from Writeback
- Adr  in  4  word offset of the selected register
- RdEn  in  1  read strobe
- WrEn  in  1  write strobe
- WriteData  in  W  write data
- ReadData  out  W  registered read data
- ReadValid  out  1  ReadData is valid this cycle

Behaviour:
- Register map (offset: register):
  - 0 CTRL: bit0 EN, bit1 CLR (write-1 pulse, reads 0), bit2 SNAP (write-1 pulse, reads 0; optional feature only).
  - 1 OVF: sticky wrap flags, bit k = counter at offset k+2; write-1-to-clear.
  - 2 CYCLES; 3 INSTR; 4 BRANCH; 5 BRTAKEN; 6 ISTALL_EV; 7 DSTALL_EV; 8 DSTALL_CYC; 9 LDRSTALL_EV; 10 FLUSHD_CYC; 11 FLUSHE_CYC; 12 WASTED_CYC; 13 PCSRC_EV.
  - 14 and 15 read 0; writes to them are ignored.
- Reset (asynchronous): all counters, OVF, edge registers, ReadData and ReadValid go to 0. CTRL.EN goes to EN_RESET. The previous-InstrE register goes to 0.
- New-instruction event: InstrE != prevInstrE and InstrE != 0. prevInstrE updates every cycle, whether or not EN is set.
- Increment rules, applied only when EN=1:
  - CYCLES increments every cycle.
  - INSTR increments on each new-instruction event.
  - BRANCH and BRTAKEN increment on a new-instruction event with BranchE or BranchTakenE high, respectively.
  - The _EV counters increment on a rising edge of their input (input=1 and prev=0). Edge registers track their inputs every cycle, so enabling counting while an input is already high does not create a spurious edge.
  - The _CYC counters increment on every cycle their input is high.
  - WASTED_CYC increments when InstrE==0 or StallE==1.
- Wrap: a counter at 2^W-1 that increments goes to 0 and sets its OVF bit in the same cycle.
- Software writes:
  - A write to a counter offset loads WriteData.
  - If a write and an increment hit the same counter in the same cycle, the write wins and the increment is lost.
- CLR (write CTRL with bit1=1) zeroes all counters and OVF on the next edge. It overrides any same-cycle increment. EN takes WriteData bit0 in that same write.
- Reads:
  - RdEn at cycle t gives ReadData and ReadValid=1 at t+1. ReadValid is 0 otherwise; ReadData holds its last value.
  - A read and write to the same offset in the same cycle returns the pre-write value.
  - If RdEn and WrEn are both high on different offsets, both operations take effect.
- Counters are updated every clock edge; there is no stall or back-pressure on the bus.

Optional Feature:
- Macro: PERFCNT_SNAPSHOT_EN.
- Defined:
  - A shadow register bank exists for offsets 2-13.
  - Writing CTRL with bit2=1 copies all live counters into the shadow bank atomically on the next edge.
  - Reads of offsets 2-13 return shadow values.
  - Writes and CLR still act on the live counters. CLR also zeroes the shadow bank.
- Undefined: there is no shadow bank, CTRL bit2 is ignored, and reads return the live counters.

Test Plan:
- Reset released with EN_RESET=1, InstrE sequence 0, A, A, B, 0, B -> after 6 cycles CYCLES=6, INSTR=3 (A, B, B), WASTED_CYC=2.
- DStall high for 5 cycles, low 2, high 3 -> DSTALL_EV=2, DSTALL_CYC=8. IStall high at the moment EN is set from 0 to 1 -> ISTALL_EV stays 0.
- New instruction with BranchE=1 and BranchTakenE=1, then one with BranchE=1 only -> BRANCH=2, BRTAKEN=1.
- Write CYCLES=0xFFFFFFFE, wait 2 cycles -> CYCLES=0 and OVF bit0=1. Write OVF=1 -> OVF reads 0.
- Write CTRL=0x3 while FlushE is high -> next read of FLUSHE_CYC returns 0 (then counts), and CTRL reads 0x1.
- With PERFCNT_SNAPSHOT_EN: write CTRL=0x5, run 10 cycles, read CYCLES -> returns the snapshot value, not the live value. Without the macro, the same read returns the live count.

Source files
------------

// File: rtl/perf_counter_unit_if.sv
// Register bus between the top-level address decoder (master) and the
// performance counter unit (slave).
`timescale 1ns/1ps
interface perf_counter_unit_if #(
  parameter int W = 32
);
  logic [3:0]   Adr;
  logic         RdEn;
  logic         WrEn;
  logic [W-1:0] WriteData;
  logic [W-1:0] ReadData;
  logic         ReadValid;

  modport master (output Adr, RdEn, WrEn, WriteData, input  ReadData, ReadValid);
  modport slave  (input  Adr, RdEn, WrEn, WriteData, output ReadData, ReadValid);
endinterface

// File: rtl/perf_counter_unit.sv
// Memory-mapped pipeline performance counters for the LEG core.
// Optional macro PERFCNT_SNAPSHOT_EN adds a shadow bank read at offsets 2-13.
`timescale 1ns/1ps
module perf_counter_unit #(
  parameter int W        = 32,
  parameter bit EN_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrE,
  input  logic        BranchE,
  input  logic        BranchTakenE,
  input  logic        StallE,
  input  logic        IStall,
  input  logic        DStall,
  input  logic        ldrStallD,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic        PCSrcW,
  perf_counter_unit_if.slave bus
);

  localparam int NCNT = 12;

  // Counter index = register offset - 2.
  localparam int IDX_CYCLES      = 0;
  localparam int IDX_INSTR       = 1;
  localparam int IDX_BRANCH      = 2;
  localparam int IDX_BRTAKEN     = 3;
  localparam int IDX_ISTALL_EV   = 4;
  localparam int IDX_DSTALL_EV   = 5;
  localparam int IDX_DSTALL_CYC  = 6;
  localparam int IDX_LDRSTALL_EV = 7;
  localparam int IDX_FLUSHD_CYC  = 8;
  localparam int IDX_FLUSHE_CYC  = 9;
  localparam int IDX_WASTED_CYC  = 10;
  localparam int IDX_PCSRC_EV    = 11;

  localparam logic [3:0] ADR_CTRL = 4'd0;
  localparam logic [3:0] ADR_OVF  = 4'd1;

  logic [W-1:0]    r_cnt [NCNT];
  logic [NCNT-1:0] r_ovf;
  logic            r_en;
  logic [31:0]     r_prev_instr;
  logic            r_istall_q;
  logic            r_dstall_q;
  logic            r_ldr_q;
  logic            r_pcsrc_q;
  logic [W-1:0]    r_rdata;
  logic            r_rvalid;

  logic            w_new_instr;
  logic            w_wr_ctrl;
  logic            w_clr;
  logic [NCNT-1:0] w_inc;
  logic [NCNT-1:0] w_bump;
  logic [NCNT-1:0] w_cnt_wr;
  logic [NCNT-1:0] w_wrap;
  logic [NCNT-1:0] w_ovf_nxt;
  logic [W-1:0]    w_rd_src [NCNT];
  logic [W-1:0]    w_rd_mux;

  assign w_new_instr = (InstrE != r_prev_instr) && (InstrE != '0);
  assign w_wr_ctrl   = bus.WrEn && (bus.Adr == ADR_CTRL);
  assign w_clr       = w_wr_ctrl && bus.WriteData[1];

  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_inc                  = '0;
    w_inc[IDX_CYCLES]      = 1'b1;
    w_inc[IDX_INSTR]       = w_new_instr;
    w_inc[IDX_BRANCH]      = w_new_instr && BranchE;
    w_inc[IDX_BRTAKEN]     = w_new_instr && BranchTakenE;
    w_inc[IDX_ISTALL_EV]   = IStall && !r_istall_q;
    w_inc[IDX_DSTALL_EV]   = DStall && !r_dstall_q;
    w_inc[IDX_DSTALL_CYC]  = DStall;
    w_inc[IDX_LDRSTALL_EV] = ldrStallD && !r_ldr_q;
    w_inc[IDX_FLUSHD_CYC]  = FlushD;
    w_inc[IDX_FLUSHE_CYC]  = FlushE;
    w_inc[IDX_WASTED_CYC]  = (InstrE == '0) || StallE;
    w_inc[IDX_PCSRC_EV]    = PCSrcW && !r_pcsrc_q;
  end

  assign w_bump = r_en ? w_inc : '0;

  // A software write to a counter beats a same-cycle increment, so it cannot wrap.
  always_comb begin
    w_cnt_wr = '0;
    w_wrap   = '0;
    for (int k = 0; k < NCNT; k++) begin
      w_cnt_wr[k] = bus.WrEn && (bus.Adr == 4'(k + 2));
      w_wrap[k]   = w_bump[k] && !w_cnt_wr[k] && (&r_cnt[k]);
    end
  end

  // A wrap in the same cycle as a write-1-to-clear keeps its flag set.
  always_comb begin
    w_ovf_nxt = r_ovf;
    if (bus.WrEn && (bus.Adr == ADR_OVF)) begin
      w_ovf_nxt = w_ovf_nxt & ~bus.WriteData[NCNT-1:0];
    end
    w_ovf_nxt = w_ovf_nxt | w_wrap;
  end

  // NOTE: the counter bank is built from flops rather than a RAM, so it takes
  // the asynchronous reset like every other register here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCNT; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NCNT; k++) begin
        if (w_clr)            r_cnt[k] <= '0;
        else if (w_cnt_wr[k]) r_cnt[k] <= bus.WriteData;
        else if (w_bump[k])   r_cnt[k] <= r_cnt[k] + W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf        <= '0;
      r_en         <= EN_RESET;
      r_prev_instr <= '0;
      r_istall_q   <= 1'b0;
      r_dstall_q   <= 1'b0;
      r_ldr_q      <= 1'b0;
      r_pcsrc_q    <= 1'b0;
    end else begin
      r_ovf        <= w_clr ? '0 : w_ovf_nxt;
      if (w_wr_ctrl) r_en <= bus.WriteData[0];
      r_prev_instr <= InstrE;
      r_istall_q   <= IStall;
      r_dstall_q   <= DStall;
      r_ldr_q      <= ldrStallD;
      r_pcsrc_q    <= PCSrcW;
    end
  end

`ifdef PERFCNT_SNAPSHOT_EN
  logic [W-1:0] r_shadow [NCNT];
  logic         w_snap;

  assign w_snap = w_wr_ctrl && bus.WriteData[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCNT; k++) r_shadow[k] <= '0;
    end else if (w_clr) begin
      for (int k = 0; k < NCNT; k++) r_shadow[k] <= '0;
    end else if (w_snap) begin
      for (int k = 0; k < NCNT; k++) r_shadow[k] <= r_cnt[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NCNT; k++) w_rd_src[k] = r_shadow[k];
  end
`else
  always_comb begin
    for (int k = 0; k < NCNT; k++) w_rd_src[k] = r_cnt[k];
  end
`endif

  // Reads see pre-edge state, so a same-cycle write to the offset is not visible yet.
  always_comb begin
    w_rd_mux = '0;
    if (bus.Adr == ADR_CTRL) begin
      w_rd_mux[0] = r_en;
    end else if (bus.Adr == ADR_OVF) begin
      w_rd_mux[NCNT-1:0] = r_ovf;
    end else begin
      for (int k = 0; k < NCNT; k++) begin
        if (bus.Adr == 4'(k + 2)) w_rd_mux = w_rd_src[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= bus.RdEn;
      if (bus.RdEn) r_rdata <= w_rd_mux;
    end
  end

  assign bus.ReadData  = r_rdata;
  assign bus.ReadValid = r_rvalid;

endmodule
